// File: rtl/hazard_flush_ctrl_if.sv
// Pipeline hazard/flush control bundle: decoded ID/EX and EX/MEM fields in,
// stall/flush/freeze controls and stall statistics out.
interface hazard_flush_ctrl_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic                   forward_en;
  logic [3:0]             src1;
  logic [3:0]             src2;
  logic                   src1_used;
  logic                   two_src;
  logic [3:0]             exe_dest;
  logic                   exe_wb_en;
  logic                   exe_mem_read;
  logic [3:0]             mem_dest;
  logic                   mem_wb_en;
  logic                   mem_access;
  logic                   branch_taken;
  logic                   hazard;
  logic                   freeze_all;
  logic                   flush;
  logic                   mem_ready;
  logic [STALL_CNT_W-1:0] stall_cycles;

  // Pipeline side: drives decoded fields, consumes controls.
  modport master (
    output forward_en, src1, src2, src1_used, two_src,
    output exe_dest, exe_wb_en, exe_mem_read,
    output mem_dest, mem_wb_en, mem_access, branch_taken,
    input  hazard, freeze_all, flush, mem_ready, stall_cycles
  );

  // Controller side.
  modport slave (
    input  forward_en, src1, src2, src1_used, two_src,
    input  exe_dest, exe_wb_en, exe_mem_read,
    input  mem_dest, mem_wb_en, mem_access, branch_taken,
    output hazard, freeze_all, flush, mem_ready, stall_cycles
  );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Hazard / flush controller: RAW and load-use stall detection, branch flush
// with deferral across memory-wait freezes, multi-cycle data-memory wait
// sequencing and a saturating stall-cycle counter.
module hazard_flush_ctrl #(
  parameter int unsigned MEM_WAIT_CYCLES = 4,
  parameter int unsigned STALL_CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_flush_ctrl_if.slave bus
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   freeze_q;
  logic                   ready_q, ready_d;
  logic                   pending_q, pending_d;
  logic                   just_exited_q, just_exited_d;
  logic [STALL_CNT_W-1:0] stall_q;

  logic m1e, m2e, m1m, m2m;
  logic hazard_raw, hazard_w, flush_w;

  // RAW match terms and combinational hazard/flush outputs.
  always_comb begin
    m1e = bus.src1_used & bus.exe_wb_en & (bus.src1 == bus.exe_dest);
    m2e = bus.two_src   & bus.exe_wb_en & (bus.src2 == bus.exe_dest);
    m1m = bus.src1_used & bus.mem_wb_en & (bus.src1 == bus.mem_dest);
    m2m = bus.two_src   & bus.mem_wb_en & (bus.src2 == bus.mem_dest);
    if (bus.forward_en) hazard_raw = bus.exe_mem_read & (m1e | m2e);
    else                hazard_raw = m1e | m2e | m1m | m2m;
    // Pipeline is already held during a memory wait; no extra stall needed.
    hazard_w = hazard_raw & ~freeze_q;
    flush_w  = ~freeze_q & (bus.branch_taken | pending_q);
  end

  // Next-state logic for the memory-wait sequencer and flush deferral.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ready_d       = 1'b0;
    just_exited_d = 1'b0;
    // A taken branch seen while frozen is held until the freeze lifts.
    pending_d     = freeze_q ? (pending_q | bus.branch_taken) : 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // The EX/MEM register is still frozen on the first cycle after a
        // wait, so its mem_access is stale and must not retrigger.
        if (bus.mem_access && !just_exited_q) begin
          if (MEM_WAIT_CYCLES == 1) begin
            ready_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
            ready_d = (MEM_WAIT_CYCLES == 2);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        // mem_ready is registered, so it is armed one cycle before cnt==1.
        if (cnt_q == 4'd2) ready_d = 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d       = ST_RUN;
          just_exited_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, wait counter, registered controls and stall statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      freeze_q      <= 1'b0;
      ready_q       <= 1'b0;
      pending_q     <= 1'b0;
      just_exited_q <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      freeze_q      <= (state_d == ST_WAIT);
      ready_q       <= ready_d;
      pending_q     <= pending_d;
      just_exited_q <= just_exited_d;
      if ((hazard_w || freeze_q) && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.hazard       = hazard_w;
  assign bus.flush        = flush_w;
  assign bus.freeze_all   = freeze_q;
  assign bus.mem_ready    = ready_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl (MEM_WAIT_CYCLES=4, 16-bit stats).
module tb_hazard_flush_ctrl;

  logic clk;
  logic rst;

  hazard_flush_ctrl_if #(.STALL_CNT_W(16)) bus ();

  hazard_flush_ctrl #(.MEM_WAIT_CYCLES(4), .STALL_CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [19:0] exp;
    logic [19:0] mask;
  } sb_t;

  // One pipeline cycle of stimulus plus the outputs required in that cycle.
  typedef struct {
    logic        ma;
    logic        br;
    logic        hz;
    logic [19:0] exp;
  } row_t;

  // Combinational hazard pattern.
  typedef struct {
    logic       fe;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       s1u;
    logic       ts;
    logic [3:0] ed;
    logic       ewb;
    logic       emr;
    logic [3:0] md;
    logic       mwb;
    logic       hz;
  } comb_t;

  localparam logic [19:0] ALL    = 20'hFFFFF;
  localparam logic [19:0] HZ_M   = 20'h80000;
  localparam logic [19:0] STAT_M = 20'h0FFFF;

  sb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic logic [19:0] ev(logic hz, logic fa, logic fl, logic mr, logic [15:0] sc);
    return {hz, fa, fl, mr, sc};
  endfunction

  function automatic logic [19:0] obs_vec();
    return {bus.hazard, bus.freeze_all, bus.flush, bus.mem_ready, bus.stall_cycles};
  endfunction

  task automatic idle();
    bus.forward_en   = 1'b0;
    bus.src1         = 4'd0;
    bus.src2         = 4'd0;
    bus.src1_used    = 1'b0;
    bus.two_src      = 1'b0;
    bus.exe_dest     = 4'd0;
    bus.exe_wb_en    = 1'b0;
    bus.exe_mem_read = 1'b0;
    bus.mem_dest     = 4'd0;
    bus.mem_wb_en    = 1'b0;
    bus.mem_access   = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  // hz=1 sets up a src1 vs exe_dest RAW match with forwarding off.
  task automatic drive(logic ma, logic br, logic hz);
    idle();
    bus.mem_access   = ma;
    bus.branch_taken = br;
    if (hz) begin
      bus.src1      = 4'd3;
      bus.src1_used = 1'b1;
      bus.exe_dest  = 4'd3;
      bus.exe_wb_en = 1'b1;
    end
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    sb_t e;
    idle();
    rst = 1'b1;
    #1;
    sb.push_back('{"reset_state", ev(0, 0, 0, 0, 16'd0), ALL});
    e = sb.pop_front();
    n_tests++;
    if ((obs_vec() & e.mask) !== (e.exp & e.mask)) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs_vec(), e.exp);
    end
    bus.mem_access = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb.push_back('{"reset_hold", ev(0, 0, 0, 0, 16'd0), ALL});
    e = sb.pop_front();
    n_tests++;
    if ((obs_vec() & e.mask) !== (e.exp & e.mask)) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs_vec(), e.exp);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
  endtask

  task automatic test_hazard_comb();
    comb_t pats[$];
    sb_t   e;
    apply_reset();
    //            fe  s1 s2 s1u ts ed ewb emr md mwb hz
    pats.push_back('{0, 3, 0, 1, 0, 3, 1, 0, 0, 0, 1});  // m1e
    pats.push_back('{0, 4, 0, 1, 0, 3, 1, 0, 0, 0, 0});  // no match
    pats.push_back('{0, 4, 0, 1, 0, 3, 1, 0, 4, 1, 1});  // m1m
    pats.push_back('{0, 0, 7, 0, 1, 3, 1, 0, 7, 1, 1});  // m2m
    pats.push_back('{0, 0, 0, 1, 0, 0, 1, 0, 9, 0, 1});  // r0 is ordinary
    pats.push_back('{0, 3, 0, 1, 0, 3, 0, 0, 0, 0, 0});  // no wb_en
    pats.push_back('{0, 3, 3, 0, 0, 3, 1, 0, 3, 1, 0});  // sources unused
    pats.push_back('{1, 0, 5, 0, 1, 5, 1, 0, 0, 0, 0});  // forwarded
    pats.push_back('{1, 0, 5, 0, 1, 5, 1, 1, 0, 0, 1});  // load-use
    pats.push_back('{1, 6, 0, 1, 0, 2, 1, 1, 6, 1, 0});  // mem-only match, fwd
    foreach (pats[i]) begin
      bus.forward_en   = pats[i].fe;
      bus.src1         = pats[i].s1;
      bus.src2         = pats[i].s2;
      bus.src1_used    = pats[i].s1u;
      bus.two_src      = pats[i].ts;
      bus.exe_dest     = pats[i].ed;
      bus.exe_wb_en    = pats[i].ewb;
      bus.exe_mem_read = pats[i].emr;
      bus.mem_dest     = pats[i].md;
      bus.mem_wb_en    = pats[i].mwb;
      sb.push_back('{$sformatf("hazard_pat%0d", i), {pats[i].hz, 19'd0}, HZ_M});
      #1;
      e = sb.pop_front();
      n_tests++;
      if ((obs_vec() & e.mask) !== (e.exp & e.mask)) begin
        n_fail++;
        $display("FAIL %s got hazard=%b want %b", e.nm, bus.hazard, pats[i].hz);
      end
    end
    idle();
  endtask

  task automatic test_mem_wait();
    row_t rows[$];
    sb_t  e;
    apply_reset();
    rows.push_back('{1, 0, 0, ev(0, 0, 0, 0, 16'd0)});
    rows.push_back('{0, 0, 0, ev(0, 1, 0, 0, 16'd0)});
    rows.push_back('{0, 0, 1, ev(0, 1, 0, 0, 16'd1)});  // hazard masked while frozen
    rows.push_back('{0, 0, 0, ev(0, 1, 0, 1, 16'd2)});
    rows.push_back('{0, 0, 0, ev(0, 0, 0, 0, 16'd3)});
    rows.push_back('{0, 0, 0, ev(0, 0, 0, 0, 16'd3)});
    foreach (rows[i]) begin
      @(posedge clk);
      #1 drive(rows[i].ma, rows[i].br, rows[i].hz);
      sb.push_back('{$sformatf("mem_wait_c%0d", i), rows[i].exp, ALL});
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if ((obs_vec() & e.mask) !== (e.exp & e.mask)) begin
        n_fail++;
        $display("FAIL %s got %h want %h", e.nm, obs_vec(), e.exp);
      end
    end
  endtask

  task automatic test_flush();
    row_t rows[$];
    sb_t  e;
    apply_reset();
    rows.push_back('{0, 1, 0, ev(0, 0, 1, 0, 16'd0)});
    rows.push_back('{0, 1, 1, ev(1, 0, 1, 0, 16'd0)});  // flush and hazard together
    rows.push_back('{1, 0, 0, ev(0, 0, 0, 0, 16'd1)});
    rows.push_back('{0, 1, 0, ev(0, 1, 0, 0, 16'd1)});  // branch while frozen
    rows.push_back('{0, 0, 0, ev(0, 1, 0, 0, 16'd2)});
    rows.push_back('{0, 0, 0, ev(0, 1, 0, 1, 16'd3)});
    rows.push_back('{0, 0, 0, ev(0, 0, 1, 0, 16'd4)});  // deferred flush
    rows.push_back('{0, 0, 0, ev(0, 0, 0, 0, 16'd4)});
    foreach (rows[i]) begin
      @(posedge clk);
      #1 drive(rows[i].ma, rows[i].br, rows[i].hz);
      sb.push_back('{$sformatf("flush_c%0d", i), rows[i].exp, ALL});
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if ((obs_vec() & e.mask) !== (e.exp & e.mask)) begin
        n_fail++;
        $display("FAIL %s got %h want %h", e.nm, obs_vec(), e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    sb_t  e;
    apply_reset();
    rows.push_back('{1, 0, 0, ev(0, 0, 0, 0, 16'd0)});
    rows.push_back('{1, 0, 0, ev(0, 1, 0, 0, 16'd0)});
    rows.push_back('{1, 0, 0, ev(0, 1, 0, 0, 16'd1)});
    rows.push_back('{1, 0, 0, ev(0, 1, 0, 1, 16'd2)});
    rows.push_back('{1, 0, 0, ev(0, 0, 0, 0, 16'd3)});  // just exited: blocked
    rows.push_back('{1, 0, 0, ev(0, 0, 0, 0, 16'd3)});  // retrigger here
    rows.push_back('{0, 0, 0, ev(0, 1, 0, 0, 16'd3)});
    rows.push_back('{0, 0, 0, ev(0, 1, 0, 0, 16'd4)});
    rows.push_back('{0, 0, 0, ev(0, 1, 0, 1, 16'd5)});
    rows.push_back('{0, 0, 0, ev(0, 0, 0, 0, 16'd6)});
    rows.push_back('{0, 0, 0, ev(0, 0, 0, 0, 16'd6)});
    foreach (rows[i]) begin
      @(posedge clk);
      #1 drive(rows[i].ma, rows[i].br, rows[i].hz);
      sb.push_back('{$sformatf("b2b_c%0d", i), rows[i].exp, ALL});
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if ((obs_vec() & e.mask) !== (e.exp & e.mask)) begin
        n_fail++;
        $display("FAIL %s got %h want %h", e.nm, obs_vec(), e.exp);
      end
    end
  endtask

  task automatic test_saturation_async_reset();
    sb_t e;
    apply_reset();
    @(posedge clk);
    #1 drive(0, 0, 1);
    repeat (65534) @(posedge clk);
    sb.push_back('{"stall_fffe", 20'h0FFFE, STAT_M});
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if ((obs_vec() & e.mask) !== (e.exp & e.mask)) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, bus.stall_cycles, 16'hFFFE);
    end
    @(posedge clk);
    sb.push_back('{"stall_ffff", 20'h0FFFF, STAT_M});
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if ((obs_vec() & e.mask) !== (e.exp & e.mask)) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, bus.stall_cycles, 16'hFFFF);
    end
    repeat (3) @(posedge clk);
    sb.push_back('{"stall_sat", 20'h0FFFF, STAT_M});
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if ((obs_vec() & e.mask) !== (e.exp & e.mask)) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, bus.stall_cycles, 16'hFFFF);
    end
    // Enter a wait, queue a flush, then reset asynchronously mid-wait.
    @(posedge clk);
    #1 drive(1, 0, 0);
    @(posedge clk);
    #1 drive(0, 1, 0);
    sb.push_back('{"wait_entered", ev(0, 1, 0, 0, 16'hFFFF), ALL});
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if ((obs_vec() & e.mask) !== (e.exp & e.mask)) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs_vec(), e.exp);
    end
    @(posedge clk);
    #1 drive(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    sb.push_back('{"async_reset", ev(0, 0, 0, 0, 16'd0), ALL});
    e = sb.pop_front();
    n_tests++;
    if ((obs_vec() & e.mask) !== (e.exp & e.mask)) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs_vec(), e.exp);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    sb.push_back('{"post_reset_no_flush", ev(0, 0, 0, 0, 16'd0), ALL});
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if ((obs_vec() & e.mask) !== (e.exp & e.mask)) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs_vec(), e.exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_hazard_comb();
    test_mem_wait();
    test_flush();
    test_back_to_back();
    test_saturation_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Pipeline control block that drives the freeze and flush inputs of the IF/ID stage registers and the ID/EX stage register.
- Reads the decoded destination and enable fields coming out of the ID/EX and EX/MEM registers, plus the branch-taken decision from EXE.
- Generates three controls: load-use/RAW stall (freeze), branch flush, and a multi-cycle data-memory wait freeze.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
- MEM_WAIT_CYCLES, 4: total cycles a data-memory access holds the pipeline frozen (legal range 1..15).
- STALL_CNT_W, 16: width of the stall-cycle statistics counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- forward_en  input  1  forwarding unit enabled; when 1, only load-use hazards stall.
- src1  input  4  Rn index of the instruction currently in ID.
- src2  input  4  Rm/Rd index of the instruction in ID.
- src1_used  input  1  ID instruction reads src1.
- two_src  input  1  ID instruction reads src2.
- exe_dest  input  4  Dest field out of the ID/EX register.
- exe_wb_en  input  1  wb_enable out of the ID/EX register.
- exe_mem_read  input  1  mem_read_enable out of the ID/EX register.
- mem_dest  input  4  Dest field out of the EX/MEM register.
- mem_wb_en  input  1  wb_enable out of the EX/MEM register.
- mem_access  input  1  EX/MEM register holds a load or store (mem_read or mem_write).
- branch_taken  input  1  EXE stage resolved a taken branch this cycle.
- hazard  output  1  combinational RAW hazard; freezes PC and IF/ID, forces ID controls to zero.
- freeze_all  output  1  registered; freezes every stage register during a memory wait.
- flush  output  1  flush to the IF/ID and ID/EX registers.
- mem_ready  output  1  one-cycle pulse on the last wait cycle.
- stall_cycles  output  STALL_CNT_W  saturating count of cycles where hazard or freeze_all was 1.

Behaviour:
- Reset: state=RUN, wait counter=0, flush_pending=0, freeze_all=0, mem_ready=0, stall_cycles=0. hazard and flush evaluate combinationally from inputs and state.
- Match terms:
  - m1e = src1_used & exe_wb_en & src1==exe_dest
  - m2e = two_src & exe_wb_en & src2==exe_dest
  - m1m, m2m: the same terms against mem_dest/mem_wb_en.
- hazard:
  - forward_en=0: hazard = m1e|m2e|m1m|m2m.
  - forward_en=1: hazard = exe_mem_read & (m1e|m2e).
  - hazard is forced to 0 while freeze_all=1 (the pipeline is already held).
- State RUN:
  - If mem_access=1: go to WAIT, load counter = MEM_WAIT_CYCLES-1, freeze_all=1 from the next cycle.
  - If MEM_WAIT_CYCLES=1: stay in RUN, pulse mem_ready the next cycle, never assert freeze_all.
- State WAIT:
  - freeze_all=1 and the counter decrements each cycle.
  - When counter==1: mem_ready=1 for that cycle, next state RUN, freeze_all drops the cycle after.
  - mem_access is ignored while in WAIT; the frozen EX/MEM register keeps it high and it must not retrigger.
  - Counter never wraps below 0.
- Re-entry: in the first RUN cycle after WAIT, mem_access only starts a new wait if the EX/MEM register has advanced. This is tracked by a 1-cycle "just_exited" flag that blocks retrigger for that one cycle.
- flush:
  - flush = (branch_taken & ~freeze_all) | (flush_pending & ~freeze_all).
  - branch_taken while freeze_all=1 sets flush_pending. flush_pending is released as a 1-cycle flush on the first cycle with freeze_all=0, then clears.
  - branch_taken and hazard in the same cycle: flush=1 and hazard is still reported. The flushed bubble makes the stall harmless.
- stall_cycles: increments by 1 every cycle (hazard|freeze_all)=1 and saturates at all-ones (no wrap).
- Async reset mid-WAIT: immediately returns to RUN, drops freeze_all, discards flush_pending and clears stall_cycles.
- Register 0 is a normal register index; no special-casing.

Test Plan:
- forward_en=0, src1=3, src1_used=1, exe_dest=3, exe_wb_en=1 -> hazard=1. With src1=4 -> hazard=0. With mem_dest=4, mem_wb_en=1 -> hazard=1.
- forward_en=1, src2=5, two_src=1, exe_dest=5, exe_wb_en=1, exe_mem_read=0 -> hazard=0. Set exe_mem_read=1 -> hazard=1.
- MEM_WAIT_CYCLES=4, one-cycle mem_access pulse in RUN -> freeze_all high for exactly 3 cycles, mem_ready pulses on the 3rd, then low. stall_cycles=3 afterward.
- branch_taken during WAIT -> flush=0 while frozen. flush=1 for exactly one cycle on the first unfrozen cycle, then 0.
- mem_access held high through the entire wait -> no retrigger in WAIT or on the just_exited cycle. A new wait starts only on the second RUN cycle if the signal is still high.
- Force stall_cycles near all-ones with a long hazard -> saturates at 0xFFFF. Assert rst mid-WAIT -> freeze_all=0 and stall_cycles=0 immediately, asynchronously.
